serial_reg_loader: RTL and testbench
====================================

Name: serial_reg_loader

Overview:
- Serial-to-parallel writer that drives the load side (enable + 8-bit data) of a parallel-load register.
- Receives asynchronous UART-style frames on a single line: 1 start bit, WIDTH data bits LSB first, 1 stop bit.
- On a valid frame, issues a one-cycle write strobe with the assembled byte. Reports framing errors and never writes on a bad frame.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are integers >= 4.
- WIDTH, 8, data bits per frame; equals the target register width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- wr_en  output  1  one-cycle write strobe to the target register's enable.
- wr_data  output  WIDTH  byte to load; stable whenever wr_en is high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Reset state: wr_en=0, wr_data=0, busy=0, frame_err=0, FSM=IDLE, counters=0. Both synchronizer flops reset to 1 (line idle).
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately, and no write occurs.
- rx passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE -> START when rx_s=0. The bit-timer clears at entry.
- START: when the timer reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s at mid-bit.
  - rx_s=1: false start; return to IDLE with no error.
  - rx_s=0: go to DATA; timer=0, bit index=0.
- DATA: sample rx_s each time the timer reaches CLKS_PER_BIT-1. Shift the sample into bit[index], LSB first.
  - After bit WIDTH-1 is sampled, go to STOP.
- STOP: sample at CLKS_PER_BIT-1.
  - rx_s=1: on the next edge, wr_en=1 for exactly one cycle and wr_data = the assembled byte. Return to IDLE in the same edge.
  - rx_s=0: on the next edge, frame_err=1 for exactly one cycle. wr_en stays 0 and wr_data is unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition (line held low) from being read as back-to-back frames.
- wr_data holds the last good byte until the next good frame; it changes only on the wr_en edge.
- A new start bit is detected in IDLE on the cycle after a write, so back-to-back frames with a full-length stop bit are accepted with no gap.
- Latency: the wr_en edge occurs 2 sync cycles + (CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT) cycles after the start-bit falling edge, + 1 cycle.
- Timer width is clog2(CLKS_PER_BIT). Index width is clog2(WIDTH+1). There is no arithmetic on data.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4), default CLKS_PER_BIT and WIDTH constants.
- One natural sub-module: sync_2ff, a 2-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.
- FSM, timer and shift register stay in the top module.

Test Plan (CLKS_PER_BIT=4, WIDTH=8):
- Good frame 0x0A -> exactly one wr_en pulse with wr_data=0x0A; frame_err stays 0; busy falls to 0 on the wr_en edge.
- Back-to-back frames 0xA5 then 0x3C, no idle gap -> two wr_en pulses; wr_data=0xA5, then 0x3C.
- Frame 0x55 with stop bit low, then line held low for 20 cycles, then high -> one frame_err pulse; no wr_en; wr_data keeps the prior 0x3C; FSM stays in WAIT_IDLE until the line is high, then returns to IDLE.
- Glitch: rx low for 1 cycle only -> no wr_en, no frame_err; returns to IDLE within CLKS_PER_BIT/2+3 cycles.
- Reset asserted at data bit 4 of frame 0xFF -> all outputs 0 immediately. A following good frame 0x81 is received correctly with wr_data=0x81.
- Frame 0x00 → wr_en pulse with wr_data=0x00, distinguishable from the reset value only by the wr_en pulse. Check the pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/serial_reg_loader_pkg.sv
// Shared definitions for the serial register loader: FSM encoding and default sizing.
package serial_reg_loader_pkg;

    // Receiver FSM states; the encoding is fixed so that state values in
    // waveforms match the documented numbering.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_WIDTH        = 8;

endpackage : serial_reg_loader_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter
// so idle-high lines (such as a UART rx) come out of reset in their idle state.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments, so r_sync takes r_meta's pre-edge value;
            // blocking ones would collapse the chain into a single flop.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/serial_reg_loader.sv
// Serial-to-parallel writer: receives start/data/stop frames on rx and issues a
// single-cycle write strobe with the assembled byte, or a frame-error pulse.
module serial_reg_loader
    import serial_reg_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH        = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int INDEX_W = $clog2(WIDTH + 1);

    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [INDEX_W-1:0] IDX_LAST  = INDEX_W'(WIDTH - 1);

    logic               w_rx_s;

    state_t             r_state,     w_state_next;
    logic [TIMER_W-1:0] r_timer,     w_timer_next;
    logic [INDEX_W-1:0] r_index,     w_index_next;
    logic [WIDTH-1:0]   r_shift,     w_shift_next;
    logic               r_wr_en,     w_wr_en_next;
    logic [WIDTH-1:0]   r_wr_data,   w_wr_data_next;
    logic               r_frame_err, w_frame_err_next;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Next-state, bit-timer, shift register and strobe decode for the frame receiver.
    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves one unassigned
        // and infers a latch.
        w_state_next     = r_state;
        w_timer_next     = r_timer + TIMER_W'(1);
        w_index_next     = r_index;
        w_shift_next     = r_shift;
        w_wr_en_next     = 1'b0;
        w_wr_data_next   = r_wr_data;
        w_frame_err_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                // Mid-bit check rejects glitches shorter than half a bit.
                if (r_timer == HALF_LAST) begin
                    w_timer_next = '0;
                    w_index_next = '0;
                    w_state_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_next = '0;
                    // Shifting in from the top lands the first (LSB) sample in bit 0
                    // after WIDTH samples.
                    w_shift_next = {w_rx_s, r_shift[WIDTH-1:1]};
                    if (r_index == IDX_LAST) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_index_next = r_index + INDEX_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_next = '0;
                    if (w_rx_s) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_data_next = r_shift;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // A held-low line (break) must return high before a new start is looked for.
                w_timer_next = '0;
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_timer_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_index     <= '0;
            // NOTE: the shift register is plain flops, not a RAM, so resetting it
            // costs nothing and keeps its contents defined from the first cycle.
            r_shift     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_index     <= w_index_next;
            r_shift     <= w_shift_next;
            r_wr_en     <= w_wr_en_next;
            r_wr_data   <= w_wr_data_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule : serial_reg_loader

// File: tb/tb_serial_reg_loader.sv
// Scoreboard bench for serial_reg_loader: the driver serialises bytes and queues the
// event each frame should produce; an independent monitor checks DUT outputs.
module tb_serial_reg_loader;

    localparam int CPB = 4;
    localparam int W   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         frame_err;

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           checks     = 0;
    int           failures   = 0;
    logic [W-1:0] model_hold = '0;
    bit           prev_wr_en = 1'b0;

    serial_reg_loader #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Hold rx at one level for a full bit time; returns 1 time unit after a rising edge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the outcome the frame must produce, then serialise it LSB first.
    task automatic send_frame(input logic [W-1:0] b, input logic stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = b;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_wr_en = 1'b0;
        end else begin
            if (wr_en) begin
                check("wr_en_single_cycle", prev_wr_en, 0);
                check("busy_low_on_write", busy, 0);
                check("write_was_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_not_error_frame", e.is_err, 0);
                    check("wr_data", wr_data, e.data);
                    model_hold = e.data;
                end
            end else begin
                check("wr_data_hold", wr_data, model_hold);
            end
            if (frame_err) begin
                check("no_write_with_err", wr_en, 0);
                check("err_was_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("err_on_bad_stop", e.is_err, 1);
                end
            end
            prev_wr_en = wr_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rb;
        logic         good;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        idle(4);

        // Single good frame.
        send_frame(8'h0A, 1'b1);
        idle(2 * CPB);

        // Back-to-back frames with no idle gap.
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(2 * CPB);

        // Bad stop bit followed by a break; receiver must wait for the line to rise.
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("busy_in_break", busy, 1);
        idle(4);
        check("idle_after_break", busy, 0);
        idle(CPB);

        // One-cycle glitch is a false start.
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(CPB / 2 + 3);
        check("idle_after_glitch", busy, 0);
        idle(CPB);

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset      = 1'b1;
        model_hold = '0;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_busy", busy, 0);
        check("abort_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(CPB);
        send_frame(8'h81, 1'b1);
        idle(2 * CPB);

        // All-zero byte: only the strobe distinguishes it from the reset value.
        send_frame(8'h00, 1'b1);
        idle(2 * CPB);

        // Random traffic with occasional bad stop bits and random gaps.
        for (int n = 0; n < 16; n++) begin
            rb   = W'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(rb, good);
            if (!good) idle(CPB);
            idle($urandom_range(0, 2 * CPB));
        end

        // Drain: every queued event must have been observed.
        for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(posedge clk);
        idle(2 * CPB);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_reg_loader
